// File: rtl/oldland_pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : oldland_pipe_ctrl_pkg
// Description : Shared types and constants for the Oldland pipeline sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package oldland_pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN          = 3'd0,
        ST_EXC_DRAIN    = 3'd1,
        ST_EXC_REDIRECT = 3'd2,
        ST_HALT_DRAIN   = 3'd3,
        ST_HALTED       = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        EXC_NONE    = 2'b00,
        EXC_ILLEGAL = 2'b01,
        EXC_SWI     = 2'b10,
        EXC_IRQ     = 2'b11
    } exc_cause_t;

    localparam logic [31:0] c_def_vector_base = 32'h0000_0000;
    localparam logic [31:0] c_def_ofs_illegal = 32'h0000_0008;
    localparam logic [31:0] c_def_ofs_swi     = 32'h0000_000c;
    localparam logic [31:0] c_def_ofs_irq     = 32'h0000_0010;

    function automatic logic [31:0] vec_offset(
        input exc_cause_t  cause,
        input logic [31:0] ofs_illegal,
        input logic [31:0] ofs_swi,
        input logic [31:0] ofs_irq
    );
        logic [31:0] ofs;
        case (cause)
            EXC_ILLEGAL: ofs = ofs_illegal;
            EXC_SWI:     ofs = ofs_swi;
            EXC_IRQ:     ofs = ofs_irq;
            default:     ofs = 32'h0;
        endcase
        return ofs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/oldland_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : oldland_pipe_ctrl_if
// Description : Pipeline status / control bundle between datapath and sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface oldland_pipe_ctrl_if;

    logic        d_valid;
    logic [3:0]  d_ra_sel;
    logic [3:0]  d_rb_sel;
    logic        x_valid;
    logic [3:0]  x_rd_sel;
    logic        x_update_rd;
    logic        x_mem_load;
    logic        x_illegal;
    logic        x_swi;
    logic        branch_taken;
    logic        mem_busy;
    logic        irq_req;
    logic        irq_en;
    logic        dbg_halt_req;
    logic        dbg_resume;

    logic        stall_fetch;
    logic        stall_decode;
    logic        stall_exec;
    logic        bubble;
    logic        flush_fetch;
    logic        flush_decode;
    logic        pc_load;
    logic [31:0] pc_load_addr;
    logic        save_state;
    logic [1:0]  exc_cause;
    logic        irq_ack;
    logic        dbg_halted;

    // Sequencer view: consumes pipeline status, drives control strobes.
    modport master (
        input  d_valid, d_ra_sel, d_rb_sel, x_valid, x_rd_sel, x_update_rd,
               x_mem_load, x_illegal, x_swi, branch_taken, mem_busy,
               irq_req, irq_en, dbg_halt_req, dbg_resume,
        output stall_fetch, stall_decode, stall_exec, bubble, flush_fetch,
               flush_decode, pc_load, pc_load_addr, save_state, exc_cause,
               irq_ack, dbg_halted
    );

    modport slave (
        output d_valid, d_ra_sel, d_rb_sel, x_valid, x_rd_sel, x_update_rd,
               x_mem_load, x_illegal, x_swi, branch_taken, mem_busy,
               irq_req, irq_en, dbg_halt_req, dbg_resume,
        input  stall_fetch, stall_decode, stall_exec, bubble, flush_fetch,
               flush_decode, pc_load, pc_load_addr, save_state, exc_cause,
               irq_ack, dbg_halted
    );

endinterface
`default_nettype wire

// File: rtl/oldland_pipe_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : oldland_pipe_ctrl_hazard_detect
// Description : Combinational load-use interlock detector.
// Revision    : 1.0 - initial release
// ============================================================================
module oldland_pipe_ctrl_hazard_detect (
    input  wire logic       i_d_valid,
    input  wire logic [3:0] i_d_ra_sel,
    input  wire logic [3:0] i_d_rb_sel,
    input  wire logic       i_x_valid,
    input  wire logic [3:0] i_x_rd_sel,
    input  wire logic       i_x_update_rd,
    input  wire logic       i_x_mem_load,
    output logic            o_load_use
);

    logic w_load_in_x;
    logic w_rd_match;

    assign w_load_in_x = i_x_valid & i_x_mem_load & i_x_update_rd;
    // Both operand fields are compared whether or not the opcode reads them.
    assign w_rd_match  = (i_x_rd_sel == i_d_ra_sel) | (i_x_rd_sel == i_d_rb_sel);
    assign o_load_use  = w_load_in_x & i_d_valid & w_rd_match;

endmodule
`default_nettype wire

// File: rtl/oldland_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : oldland_pipe_ctrl
// Description : Pipeline sequencer: stalls, flushes, exception and debug entry.
// Revision    : 1.0 - initial release
// ============================================================================
module oldland_pipe_ctrl
    import oldland_pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] VECTOR_BASE = c_def_vector_base,
    parameter logic [31:0] OFS_ILLEGAL = c_def_ofs_illegal,
    parameter logic [31:0] OFS_SWI     = c_def_ofs_swi,
    parameter logic [31:0] OFS_IRQ     = c_def_ofs_irq
) (
    input  wire logic            clk,
    input  wire logic            rst,
    oldland_pipe_ctrl_if.master  pipe
);

    state_t      r_state;
    state_t      w_next_state;
    exc_cause_t  r_exc_cause;
    exc_cause_t  w_next_cause;
    exc_cause_t  w_new_cause;
    logic        r_rst_d;
    logic        w_quiet;
    logic        w_load_use;
    logic        w_exc_illegal;
    logic        w_exc_swi;
    logic        w_exc_irq;
    logic        w_exc_any;

    logic        w_stall_fetch;
    logic        w_stall_decode;
    logic        w_stall_exec;
    logic        w_bubble;
    logic        w_flush_fetch;
    logic        w_flush_decode;
    logic        w_pc_load;
    logic [31:0] w_pc_load_addr;
    logic        w_save_state;
    logic        w_irq_ack;
    logic        w_dbg_halted;

    oldland_pipe_ctrl_hazard_detect u_hazard (
        .i_d_valid     (pipe.d_valid),
        .i_d_ra_sel    (pipe.d_ra_sel),
        .i_d_rb_sel    (pipe.d_rb_sel),
        .i_x_valid     (pipe.x_valid),
        .i_x_rd_sel    (pipe.x_rd_sel),
        .i_x_update_rd (pipe.x_update_rd),
        .i_x_mem_load  (pipe.x_mem_load),
        .o_load_use    (w_load_use)
    );

    // Outputs stay silent during reset and for one cycle after it.
    assign w_quiet = rst | r_rst_d;

    assign w_exc_illegal = pipe.x_valid & pipe.x_illegal;
    assign w_exc_swi     = pipe.x_valid & pipe.x_swi;
    assign w_exc_irq     = pipe.x_valid & pipe.irq_req & pipe.irq_en;
    assign w_exc_any     = w_exc_illegal | w_exc_swi | w_exc_irq;

    always_comb begin
        w_new_cause = EXC_IRQ;
        if (w_exc_illegal)
            w_new_cause = EXC_ILLEGAL;
        else if (w_exc_swi)
            w_new_cause = EXC_SWI;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_exc_cause <= EXC_NONE;
            r_rst_d     <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_exc_cause <= w_next_cause;
            r_rst_d     <= 1'b0;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_next_cause   = r_exc_cause;
        w_stall_fetch  = 1'b0;
        w_stall_decode = 1'b0;
        w_stall_exec   = 1'b0;
        w_bubble       = 1'b0;
        w_flush_fetch  = 1'b0;
        w_flush_decode = 1'b0;
        w_pc_load      = 1'b0;
        w_pc_load_addr = 32'h0;
        w_save_state   = 1'b0;
        w_irq_ack      = 1'b0;
        w_dbg_halted   = 1'b0;

        if (w_quiet) begin
            w_next_state = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_exc_any) begin
                        w_next_cause   = w_new_cause;
                        w_flush_fetch  = 1'b1;
                        w_flush_decode = 1'b1;
                        w_next_state   = ST_EXC_DRAIN;
                    end else if (pipe.dbg_halt_req) begin
                        w_flush_fetch  = 1'b1;
                        w_flush_decode = 1'b1;
                        w_next_state   = ST_HALT_DRAIN;
                    end else if (pipe.branch_taken) begin
                        w_flush_fetch  = 1'b1;
                        w_flush_decode = 1'b1;
                    end else if (pipe.mem_busy) begin
                        w_stall_fetch  = 1'b1;
                        w_stall_decode = 1'b1;
                        w_stall_exec   = 1'b1;
                    end else if (w_load_use) begin
                        w_stall_fetch  = 1'b1;
                        w_stall_decode = 1'b1;
                        w_bubble       = 1'b1;
                    end
                end

                ST_EXC_DRAIN: begin
                    w_stall_fetch  = 1'b1;
                    w_stall_decode = 1'b1;
                    w_stall_exec   = 1'b1;
                    w_flush_decode = 1'b1;
                    if (!pipe.mem_busy)
                        w_next_state = ST_EXC_REDIRECT;
                end

                ST_EXC_REDIRECT: begin
                    w_pc_load      = 1'b1;
                    w_save_state   = 1'b1;
                    w_flush_fetch  = 1'b1;
                    w_flush_decode = 1'b1;
                    w_pc_load_addr = VECTOR_BASE +
                                     vec_offset(r_exc_cause, OFS_ILLEGAL, OFS_SWI, OFS_IRQ);
                    w_irq_ack      = (r_exc_cause == EXC_IRQ);
                    w_next_state   = ST_RUN;
                end

                ST_HALT_DRAIN: begin
                    w_stall_fetch  = 1'b1;
                    w_stall_decode = 1'b1;
                    w_stall_exec   = 1'b1;
                    if (!pipe.mem_busy)
                        w_next_state = ST_HALTED;
                end

                ST_HALTED: begin
                    w_dbg_halted   = 1'b1;
                    w_stall_fetch  = 1'b1;
                    w_stall_decode = 1'b1;
                    w_stall_exec   = 1'b1;
                    if (pipe.dbg_resume) begin
                        w_flush_fetch = 1'b1;
                        w_next_state  = ST_RUN;
                    end
                end

                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    assign pipe.stall_fetch  = w_stall_fetch;
    assign pipe.stall_decode = w_stall_decode;
    assign pipe.stall_exec   = w_stall_exec;
    assign pipe.bubble       = w_bubble;
    assign pipe.flush_fetch  = w_flush_fetch;
    assign pipe.flush_decode = w_flush_decode;
    assign pipe.pc_load      = w_pc_load;
    assign pipe.pc_load_addr = w_pc_load_addr;
    assign pipe.save_state   = w_save_state;
    assign pipe.exc_cause    = w_quiet ? EXC_NONE : r_exc_cause;
    assign pipe.irq_ack      = w_irq_ack;
    assign pipe.dbg_halted   = w_dbg_halted;

endmodule
`default_nettype wire

// File: doc/oldland_pipe_ctrl.md
Name: oldland_pipe_ctrl

Overview:
Central pipeline sequencer for the Oldland CPU. It sits beside the fetch/decode/execute/memory pipeline and generates every stage stall, flush and PC-redirect strobe. It covers load-use interlocks, memory-stall propagation, branch flushes, exception/IRQ entry sequencing and debug halt/resume. Decode and execute stay free of control policy; all hazard priority lives here.

Parameters:
VECTOR_BASE, 32'h0000_0000, exception vector table base (word aligned).
OFS_ILLEGAL, 32'h8, vector offset for illegal instruction.
OFS_SWI, 32'hc, vector offset for software interrupt.
OFS_IRQ, 32'h10, vector offset for external interrupt.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
d_valid  in  1  instruction currently in decode is valid (fetched)
d_ra_sel  in  4  decode-stage ra index
d_rb_sel  in  4  decode-stage rb index
x_valid  in  1  execute-stage instruction valid (registered i_valid)
x_rd_sel  in  4  execute-stage destination register
x_update_rd  in  1  execute-stage instruction writes rd
x_mem_load  in  1  execute-stage instruction is a load
x_illegal  in  1  execute-stage instruction flagged illegal
x_swi  in  1  execute-stage instruction is swi
branch_taken  in  1  execute resolved a taken branch/call/rfe this cycle
mem_busy  in  1  memory stage waiting for bus ack
irq_req  in  1  level-sensitive external interrupt
irq_en  in  1  interrupts enabled (PSR.I)
dbg_halt_req  in  1  debugger halt request (level)
dbg_resume  in  1  debugger resume pulse
stall_fetch  out  1  hold PC and fetch register
stall_decode  out  1  hold decode output register
stall_exec  out  1  hold execute output register
bubble  out  1  load decode->execute register with invalid (nop)
flush_fetch  out  1  discard fetched instruction
flush_decode  out  1  discard decode output (clear i_valid)
pc_load  out  1  PC <= pc_load_addr next cycle
pc_load_addr  out  32  exception vector address
save_state  out  1  one-cycle strobe: copy PSR to SPSR, PC to saved-PC
exc_cause  out  2  00 none, 01 illegal, 10 swi, 11 irq
irq_ack  out  1  one-cycle acknowledge of IRQ entry
dbg_halted  out  1  core halted for debugger

Behaviour:
- States (registered, 3-bit encoding in package): RUN, EXC_DRAIN, EXC_REDIRECT, HALT_DRAIN, HALTED.
- Reset: state=RUN, exc_cause=00, pending cause cleared. All outputs 0 in the reset cycle and the cycle after. Reset mid-sequence aborts to RUN with no pc_load.
- Outputs are combinational from state plus inputs. State and exc_cause are registered.
- RUN, priority order (highest first):
  - Exception: x_valid & (x_illegal | x_swi), or irq_req & irq_en & x_valid. Illegal beats swi beats irq. Latch cause, flush_fetch=flush_decode=1, go to EXC_DRAIN.
  - Debug halt: dbg_halt_req. flush_fetch=flush_decode=1, go to HALT_DRAIN.
  - branch_taken: flush_fetch=flush_decode=1 the same cycle; no stall; stay RUN.
  - mem_busy: stall_fetch=stall_decode=stall_exec=1.
  - Load-use: x_valid & x_mem_load & x_update_rd & d_valid & (x_rd_sel==d_ra_sel | x_rd_sel==d_rb_sel). Assert stall_fetch, stall_decode and bubble for exactly one cycle. Next cycle the load has advanced, so the condition clears naturally. The compare is conservative: rd compares against both fields regardless of operand use.
- EXC_DRAIN: all stalls=1, flush_decode=1. Stay while mem_busy; when !mem_busy go to EXC_REDIRECT. branch_taken is ignored.
- EXC_REDIRECT (exactly 1 cycle):
  - pc_load=1, save_state=1, flush_fetch=flush_decode=1.
  - pc_load_addr = VECTOR_BASE + offset[cause], 32-bit wrap, no carry out.
  - irq_ack=1 iff cause=11.
  - Next state RUN. exc_cause holds its value until the next exception.
- HALT_DRAIN: all stalls=1. When !mem_busy go to HALTED.
- HALTED: dbg_halted=1, all stalls=1. dbg_resume goes to RUN (flush_fetch=1 that cycle). IRQs are ignored while halted and stay pending at level.
- Simultaneous dbg_halt_req and exception: exception wins; the halt is honoured in RUN after the redirect.
- pc_load_addr is 0 whenever pc_load=0.

Decomposition:
- Shared package/defines in cpu_defines.v: state encodings, exc_cause codes (EXC_NONE/ILLEGAL/SWI/IRQ), default vector offsets.
- One sub-module is natural: oldland_hazard_detect, the combinational load-use compare producing bubble/stall requests.
- The FSM and priority logic stay in oldland_pipe_ctrl.

Test Plan:
- Load-use: x_mem_load=1, x_update_rd=1, x_rd_sel=3, d_ra_sel=3, d_valid=1 -> stall_fetch=stall_decode=bubble=1 for one cycle only. Repeat with d_rb_sel=3 -> same. With x_update_rd=0 -> no stall.
- Branch vs load-use same cycle: branch_taken=1 plus hazard -> flush_fetch=flush_decode=1, bubble=0, stall=0.
- Illegal during mem_busy: x_illegal=1, mem_busy=1 for 3 cycles -> EXC_DRAIN, all stalls held 3 cycles. Then one EXC_REDIRECT cycle with pc_load=1, pc_load_addr=0x8, save_state=1, exc_cause=01.
- IRQ entry: irq_req=1, irq_en=1, x_valid=1, VECTOR_BASE=0x1000 -> two cycles later pc_load_addr=0x1010, irq_ack=1 for one cycle. With irq_en=0 -> no entry.
- Swi and illegal together -> exc_cause=01, pc_load_addr=0x8.
- Debug: dbg_halt_req=1 -> dbg_halted=1 after drain, stalls held. dbg_resume pulse -> RUN, flush_fetch=1. Reset asserted in EXC_DRAIN -> RUN, no pc_load, exc_cause=00.
